// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter/receiver pair.
//   DATA_BITS    : data bits per frame (8N1 framing)
//   uart_state_e : state encoding used by both the TX and RX FSMs
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling.
//   i_Clock, i_Rst_L : clock, async active-low reset
//   i_RX_Serial      : asynchronous serial line, idle high
//   o_RX_DV          : one-cycle pulse when a frame with a valid stop bit lands
//   o_RX_Byte        : last good byte, held until the next good frame
//
// state   | meaning
// IDLE    | waiting for a low line
// START   | counting to mid start bit, rejects glitches
// DATA    | sampling data bit bit_idx once per bit period
// STOP    | sampling stop bit, publishes byte if high
// CLEANUP | one-cycle gap, o_RX_DV high if frame was good
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  localparam int               CW       = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0]    CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(DATA_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_d;
  logic             dv_d;
  logic             rx_meta, rx_sync;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      o_RX_Byte <= '0;
      o_RX_DV   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      o_RX_Byte <= byte_d;
      o_RX_DV   <= dv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = o_RX_Byte;
    dv_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_sync) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_sync ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Counter was realigned to mid start bit, so each full period lands mid-bit.
      S_DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync;
          if (idx_q == IDX_MAX) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = S_CLEANUP;
          if (rx_sync) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLEANUP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter.
//   i_Clock, i_Rst_L : clock, async active-low reset
//   i_TX_DV          : one-cycle send request (honoured only in IDLE)
//   i_TX_Byte        : byte latched when i_TX_DV is accepted
//   o_TX_Active      : high for start..stop of a frame
//   o_TX_Serial      : serial line, idle high
//   o_TX_Done        : one-cycle pulse after the stop bit
//
// state   | meaning
// IDLE    | line high, waiting for i_TX_DV
// START   | driving start bit (low)
// DATA    | driving data bit bit_idx, LSB first
// STOP    | driving stop bit (high)
// CLEANUP | one-cycle gap, o_TX_Done high
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int               CW      = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0]    CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             serial_d, active_d, done_d;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      byte_q      <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      o_TX_Serial <= serial_d;
      o_TX_Active <= active_d;
      o_TX_Done   <= done_d;
    end
  end

  // Outputs are computed from the next state so the line is driven straight
  // from a flop and never glitches between bits.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    serial_d = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (i_TX_DV) begin
          byte_d   = i_TX_Byte;
          state_d  = S_START;
          serial_d = 1'b0;
          active_d = 1'b1;
        end
      end
      S_START: begin
        active_d = 1'b1;
        serial_d = 1'b0;
        if (cnt_q == CNT_MAX) begin
          cnt_d    = '0;
          state_d  = S_DATA;
          serial_d = byte_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        active_d = 1'b1;
        serial_d = byte_q[idx_q];
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (idx_q == IDX_MAX) begin
            idx_d    = '0;
            state_d  = S_STOP;
            serial_d = 1'b1;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            serial_d = byte_q[idx_q + IDX_W'(1)];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        active_d = 1'b1;
        if (cnt_q == CNT_MAX) begin
          cnt_d    = '0;
          state_d  = S_CLEANUP;
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLEANUP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_trx.sv
// uart_trx: independent 8N1 UART transmitter and receiver sharing one clock.
//   i_Clock, i_Rst_L                               : clock, async active-low reset
//   i_TX_DV, i_TX_Byte                             : transmit request and data
//   o_TX_Active, o_TX_Serial, o_TX_Done            : transmit status and line
//   i_RX_Serial                                    : receive line (asynchronous)
//   o_RX_DV, o_RX_Byte                             : received byte strobe and data
module uart_trx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_Clock     (i_Clock),
    .i_Rst_L     (i_Rst_L),
    .i_TX_DV     (i_TX_DV),
    .i_TX_Byte   (i_TX_Byte),
    .o_TX_Active (o_TX_Active),
    .o_TX_Serial (o_TX_Serial),
    .o_TX_Done   (o_TX_Done)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_Clock     (i_Clock),
    .i_Rst_L     (i_Rst_L),
    .i_RX_Serial (i_RX_Serial),
    .o_RX_DV     (o_RX_DV),
    .o_RX_Byte   (o_RX_Byte)
  );

endmodule

// File: tb/tb_uart_trx.sv
`timescale 1ns/1ps
module tb_uart_trx;

  localparam int CPB = 217;

  logic       r_Clock = 1'b0;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active, tx_serial, tx_done;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       loopback;
  logic       manual_rx;
  logic       rx_line;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         dv_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] rx_hist[$];

  assign rx_line = loopback ? (tx_active ? tx_serial : 1'b1) : manual_rx;

  always #20 r_Clock = ~r_Clock;

  uart_trx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (r_Clock),
    .i_Rst_L     (rst_n),
    .i_TX_DV     (tx_dv),
    .i_TX_Byte   (tx_byte),
    .o_TX_Active (tx_active),
    .o_TX_Serial (tx_serial),
    .o_TX_Done   (tx_done),
    .i_RX_Serial (rx_line),
    .o_RX_DV     (rx_dv),
    .o_RX_Byte   (rx_byte)
  );

  always @(posedge r_Clock) cyc <= cyc + 1;

  always @(negedge r_Clock) begin
    if (rx_dv === 1'b1) begin
      dv_cnt = dv_cnt + 1;
      rx_hist.push_back(rx_byte);
    end
    if (tx_done === 1'b1) done_cnt = done_cnt + 1;
  end

  initial begin
    #2400000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge r_Clock);
  endtask

  task automatic clear_counts();
    dv_cnt = 0;
    done_cnt = 0;
    rx_hist.delete();
  endtask

  // Request lands on the posedge between the two negedges; returns half a cycle later.
  task automatic pulse_tx(input logic [7:0] b);
    @(negedge r_Clock);
    tx_dv = 1'b1;
    tx_byte = b;
    @(negedge r_Clock);
    tx_dv = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    int g;
    g = 0;
    while (tx_done !== 1'b1 && g < 12 * CPB) begin
      @(negedge r_Clock);
      g++;
    end
    seen = (tx_done === 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      manual_rx = frame[k];
      repeat (CPB) @(negedge r_Clock);
    end
    manual_rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    n_vec++; if (tx_serial !== 1'b1) begin n_err++; $display("FAIL reset_tx_serial: got %b exp 1", tx_serial); end
    n_vec++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL reset_tx_active: got %b exp 0", tx_active); end
    n_vec++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL reset_tx_done: got %b exp 0", tx_done); end
    n_vec++; if (rx_dv !== 1'b0) begin n_err++; $display("FAIL reset_rx_dv: got %b exp 0", rx_dv); end
    n_vec++; if (rx_byte !== 8'h00) begin n_err++; $display("FAIL reset_rx_byte: got %h exp 00", rx_byte); end
    rst_n = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_loopback();
    logic [9:0] frame;
    int start, target;
    bit seen;
    loopback = 1'b1;
    wait_cycles(2);
    clear_counts();
    frame = {1'b1, 8'hAB, 1'b0};
    pulse_tx(8'hAB);
    start = cyc;
    n_vec++; if (tx_active !== 1'b1) begin n_err++; $display("FAIL lb_active_on_start: got %b exp 1", tx_active); end
    for (int k = 0; k < 10; k++) begin
      target = start + CPB * k + CPB / 2;
      while (cyc < target) @(negedge r_Clock);
      n_vec++;
      if (tx_serial !== frame[k]) begin
        n_err++;
        $display("FAIL lb_tx_bit%0d: got %b exp %b", k, tx_serial, frame[k]);
      end
    end
    wait_done(seen);
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL lb_done_timeout: done not seen, required within %0d cycles", 12 * CPB);
    end else begin
      if (cyc - start !== 10 * CPB) begin
        n_err++;
        $display("FAIL lb_done_latency: got %0d cycles exp %0d", cyc - start, 10 * CPB);
      end
    end
    n_vec++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL lb_active_at_done: got %b exp 0", tx_active); end
    wait_cycles(20);
    n_vec++; if (dv_cnt !== 1) begin n_err++; $display("FAIL lb_dv_count: got %0d exp 1", dv_cnt); end
    n_vec++; if (rx_byte !== 8'hAB) begin n_err++; $display("FAIL lb_rx_byte: got %h exp ab", rx_byte); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL lb_done_count: got %0d exp 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int s0, s1;
    bit seen;
    clear_counts();
    pulse_tx(8'h00);
    s0 = cyc;
    wait_done(seen);
    n_vec++; if (!seen) begin n_err++; $display("FAIL b2b_done1_timeout: done not seen, required"); end
    @(posedge r_Clock);
    #1 tx_dv = 1'b1;
    tx_byte = 8'hFF;
    @(posedge r_Clock);
    #1 tx_dv = 1'b0;
    @(negedge r_Clock);
    s1 = cyc;
    n_vec++; if (tx_serial !== 1'b0) begin n_err++; $display("FAIL b2b_second_start: got %b exp 0", tx_serial); end
    n_vec++; if (s1 - s0 !== 10 * CPB + 2) begin n_err++; $display("FAIL b2b_period: got %0d exp %0d", s1 - s0, 10 * CPB + 2); end
    wait_done(seen);
    n_vec++; if (!seen) begin n_err++; $display("FAIL b2b_done2_timeout: done not seen, required"); end
    wait_cycles(20);
    n_vec++; if (dv_cnt !== 2) begin n_err++; $display("FAIL b2b_dv_count: got %0d exp 2", dv_cnt); end
    if (rx_hist.size() >= 2) begin
      n_vec++; if (rx_hist[0] !== 8'h00) begin n_err++; $display("FAIL b2b_byte0: got %h exp 00", rx_hist[0]); end
      n_vec++; if (rx_hist[1] !== 8'hFF) begin n_err++; $display("FAIL b2b_byte1: got %h exp ff", rx_hist[1]); end
    end else begin
      n_vec++; n_err++;
      $display("FAIL b2b_history: got %0d bytes exp 2", rx_hist.size());
    end
    n_vec++; if (done_cnt !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d exp 2", done_cnt); end
  endtask

  task automatic test_busy();
    bit seen;
    clear_counts();
    pulse_tx(8'h3C);
    wait_cycles(500);
    pulse_tx(8'h55);
    wait_done(seen);
    n_vec++; if (!seen) begin n_err++; $display("FAIL busy_done_timeout: done not seen, required"); end
    wait_cycles(20);
    n_vec++; if (rx_byte !== 8'h3C) begin n_err++; $display("FAIL busy_rx_byte: got %h exp 3c", rx_byte); end
    wait_cycles(2500);
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL busy_done_count: got %0d exp 1", done_cnt); end
    n_vec++; if (dv_cnt !== 1) begin n_err++; $display("FAIL busy_dv_count: got %0d exp 1", dv_cnt); end
    n_vec++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL busy_idle_after: got %b exp 0", tx_active); end
  endtask

  task automatic test_glitch();
    loopback = 1'b0;
    manual_rx = 1'b1;
    wait_cycles(5);
    clear_counts();
    manual_rx = 1'b0;
    wait_cycles(50);
    manual_rx = 1'b1;
    wait_cycles(400);
    n_vec++; if (dv_cnt !== 0) begin n_err++; $display("FAIL glitch_dv_count: got %0d exp 0", dv_cnt); end
    n_vec++; if (rx_byte !== 8'h3C) begin n_err++; $display("FAIL glitch_rx_byte: got %h exp 3c", rx_byte); end
    send_rx(8'hC5, 1'b1);
    wait_cycles(50);
    n_vec++; if (dv_cnt !== 1) begin n_err++; $display("FAIL glitch_recover_dv: got %0d exp 1", dv_cnt); end
    n_vec++; if (rx_byte !== 8'hC5) begin n_err++; $display("FAIL glitch_recover_byte: got %h exp c5", rx_byte); end
  endtask

  task automatic test_framing();
    clear_counts();
    send_rx(8'h96, 1'b0);
    wait_cycles(3000);
    n_vec++; if (dv_cnt !== 0) begin n_err++; $display("FAIL frame_err_dv: got %0d exp 0", dv_cnt); end
    n_vec++; if (rx_byte !== 8'hC5) begin n_err++; $display("FAIL frame_err_byte: got %h exp c5", rx_byte); end
  endtask

  task automatic test_mid_reset();
    loopback = 1'b1;
    wait_cycles(5);
    clear_counts();
    // 8'hA5 bit1 is 0, so the line is low at this point of the frame.
    pulse_tx(8'hA5);
    wait_cycles(500);
    n_vec++; if (tx_serial !== 1'b0) begin n_err++; $display("FAIL mid_line_before_reset: got %b exp 0", tx_serial); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (tx_serial !== 1'b1) begin n_err++; $display("FAIL mid_rst_tx_serial: got %b exp 1", tx_serial); end
    n_vec++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx_active: got %b exp 0", tx_active); end
    n_vec++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx_done: got %b exp 0", tx_done); end
    n_vec++; if (rx_dv !== 1'b0) begin n_err++; $display("FAIL mid_rst_rx_dv: got %b exp 0", rx_dv); end
    n_vec++; if (rx_byte !== 8'h00) begin n_err++; $display("FAIL mid_rst_rx_byte: got %h exp 00", rx_byte); end
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(3000);
    n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL mid_rst_no_done: got %0d exp 0", done_cnt); end
    n_vec++; if (dv_cnt !== 0) begin n_err++; $display("FAIL mid_rst_no_dv: got %0d exp 0", dv_cnt); end
    n_vec++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL mid_rst_idle: got %b exp 0", tx_active); end
  endtask

  initial begin
    rst_n = 1'b0;
    tx_dv = 1'b0;
    tx_byte = 8'h00;
    loopback = 1'b1;
    manual_rx = 1'b1;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_busy();
    test_glitch();
    test_framing();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
